slowclk_monitor: RTL and testbench

//  Fast-domain consumer of a divided/slow clock (e.g. the 50MHz-derived game tick) or any slow square wave.

---
 rtl/slowclk_pkg.sv | 31 +++
 rtl/slowclk_sync_edge.sv | 40 ++++
 rtl/slowclk_monitor.sv | 147 ++++++++++++++
 tb/tb_slowclk_monitor.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/slowclk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slowclk_pkg : shared types, defaults and tolerance compare            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package slowclk_pkg;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    LOCKED = 2'd1,
    LOST   = 2'd2
  } slowclk_state_t;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_CNT_W       = 32;
  localparam int unsigned DEF_EXPECT_HALF = 25000000;
  localparam int unsigned DEF_TOL         = 1024;
  localparam int unsigned DEF_LOCK_EDGES  = 4;

  // Magnitude-of-difference compare on zero-extended operands, so it never
  // overflows whatever the counter width is.
  function automatic logic within_tol(input logic [63:0] meas,
                                      input logic [63:0] target,
                                      input logic [63:0] tol);
    logic [63:0] diff;
    diff = (meas >= target) ? (meas - target) : (target - meas);
    return diff <= tol;
  endfunction

endpackage
`default_nettype wire

// File: rtl/slowclk_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_edge : synchroniser chain plus previous-level register           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic iclk,
  input  logic reset,
  input  logic islow,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], islow};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge iclk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule
`default_nettype wire

// File: rtl/slowclk_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slowclk_monitor : slow-clock edge ticks, half-period measure, lock    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module slowclk_monitor
  import slowclk_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned EXPECT_HALF = DEF_EXPECT_HALF,
  parameter int unsigned TOL         = DEF_TOL,
  parameter int unsigned LOCK_EDGES  = DEF_LOCK_EDGES
) (
  input  logic             iclk,
  input  logic             reset,
  input  logic             islow,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] half_period,
  output logic             locked,
  output logic             lost
);

  localparam int unsigned      GOOD_W   = (LOCK_EDGES > 1) ? $clog2(LOCK_EDGES) : 1;
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_EDGES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [63:0]      STALL_AT = 64'(EXPECT_HALF) + 64'(TOL);

  logic level_w, rise_w, fall_w, edge_w, measure_w, good_w, stall_w;
  logic [CNT_W-1:0] meas_w;

  logic [CNT_W-1:0]  cnt_q, cnt_d, half_period_q, half_period_d;
  logic              first_seen_q, first_seen_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  slowclk_state_t    state_q, state_d;
  logic rise_tick_q, rise_tick_d, fall_tick_q, fall_tick_d;
  logic locked_q, locked_d, lost_q, lost_d;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .iclk  (iclk),
    .reset (reset),
    .islow (islow),
    .level (level_w),
    .rise  (rise_w),
    .fall  (fall_w)
  );

  assign edge_w    = rise_w | fall_w;
  assign measure_w = edge_w & first_seen_q;
  // A saturated counter reports the saturated value rather than wrapping.
  assign meas_w    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
  assign good_w    = within_tol(64'(meas_w), 64'(EXPECT_HALF), 64'(TOL));
  assign stall_w   = !edge_w && (64'(cnt_q) == STALL_AT);

  always_comb begin
    cnt_d         = cnt_q;
    first_seen_d  = first_seen_q;
    half_period_d = half_period_q;
    if (edge_w) begin
      cnt_d        = '0;
      first_seen_d = 1'b1;
      if (first_seen_q) half_period_d = meas_w;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge iclk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      first_seen_q  <= 1'b0;
      half_period_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      first_seen_q  <= first_seen_d;
      half_period_q <= half_period_d;
    end
  end

  always_ff @(posedge iclk or posedge reset) begin
    if (reset) begin
      state_q     <= ACQ;
      good_cnt_q  <= '0;
      rise_tick_q <= 1'b0;
      fall_tick_q <= 1'b0;
      locked_q    <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      rise_tick_q <= rise_tick_d;
      fall_tick_q <= fall_tick_d;
      locked_q    <= locked_d;
      lost_q      <= lost_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    case (state_q)
      ACQ: begin
        if (measure_w) begin
          if (!good_w) begin
            good_cnt_d = '0;
          end else if (good_cnt_q == GOOD_LAST) begin
            state_d    = LOCKED;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + GOOD_W'(1);
          end
        end
      end
      LOCKED: begin
        if ((measure_w && !good_w) || stall_w) state_d = LOST;
      end
      LOST: begin
        // The edge that leaves LOST only restarts acquisition.
        if (measure_w) begin
          state_d    = ACQ;
          good_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ACQ;
        good_cnt_d = '0;
      end
    endcase
  end

  // Status flags follow the next state so they line up with the ticks.
  always_comb begin
    rise_tick_d = edge_w & level_w;
    fall_tick_d = edge_w & ~level_w;
    locked_d    = (state_d == LOCKED);
    lost_d      = (state_d == LOST);
  end

  assign rise_tick   = rise_tick_q;
  assign fall_tick   = fall_tick_q;
  assign half_period = half_period_q;
  assign locked      = locked_q;
  assign lost        = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_slowclk_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_slowclk_monitor : directed bench with reference model              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_slowclk_monitor;

  localparam int EXP_H = 8;
  localparam int TOLV  = 1;
  localparam int LOCKN = 4;
  localparam int MAX8  = 255;
  localparam int MAX4  = 15;

  logic       iclk = 1'b0;
  logic       reset = 1'b1;
  logic       islow = 1'b0;
  logic       rise_tick, fall_tick, locked, lost;
  logic [7:0] half_period;
  logic       rise_tick4, fall_tick4, locked4, lost4;
  logic [3:0] half_period4;

  always #5 iclk = ~iclk;

  slowclk_monitor #(.SYNC_STAGES(2), .CNT_W(8), .EXPECT_HALF(EXP_H), .TOL(TOLV),
                    .LOCK_EDGES(LOCKN)) dut (
    .iclk(iclk), .reset(reset), .islow(islow),
    .rise_tick(rise_tick), .fall_tick(fall_tick), .half_period(half_period),
    .locked(locked), .lost(lost)
  );

  slowclk_monitor #(.SYNC_STAGES(2), .CNT_W(4), .EXPECT_HALF(EXP_H), .TOL(TOLV),
                    .LOCK_EDGES(LOCKN)) dut4 (
    .iclk(iclk), .reset(reset), .islow(islow),
    .rise_tick(rise_tick4), .fall_tick(fall_tick4), .half_period(half_period4),
    .locked(locked4), .lost(lost4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model working on the raw per-cycle samples of islow: runs of
  // equal samples are half-periods; results appear two cycles later.
  typedef struct packed {
    logic        rise;
    logic        fall;
    logic        lck;
    logic        lst;
    logic [31:0] hp;
    logic [31:0] hp4;
  } exp_t;

  exp_t q0, q1, exp_now, r;
  logic m_prev;
  int   m_run, m_goods, m_hp, m_hp4, meas, meas4;
  bit   m_first, m_locked, m_lost, trans, good;

  always @(posedge iclk) begin
    if (reset) begin
      q0 = '0; q1 = '0; exp_now = '0;
      m_prev = 1'b0; m_run = 0; m_goods = 0; m_hp = 0; m_hp4 = 0;
      m_first = 0; m_locked = 0; m_lost = 0;
    end else begin
      trans  = (islow != m_prev);
      m_prev = islow;
      if (m_run < 1000000) m_run++;
      if (trans) begin
        if (m_first) begin
          meas  = (m_run > MAX8) ? MAX8 : m_run;
          meas4 = (m_run > MAX4) ? MAX4 : m_run;
          m_hp  = meas;
          m_hp4 = meas4;
          good  = ((meas > EXP_H) ? meas - EXP_H : EXP_H - meas) <= TOLV;
          if (m_lost) begin
            m_lost  = 0;
            m_goods = 0;
          end else if (m_locked) begin
            if (!good) begin m_locked = 0; m_lost = 1; end
          end else if (good) begin
            m_goods++;
            if (m_goods == LOCKN) begin m_locked = 1; m_goods = 0; end
          end else begin
            m_goods = 0;
          end
        end else begin
          m_first = 1;
        end
        m_run = 0;
      end else if (m_locked && m_run == EXP_H + TOLV + 1) begin
        m_locked = 0;
        m_lost   = 1;
      end
      r.rise = trans && islow;
      r.fall = trans && !islow;
      r.lck  = m_locked;
      r.lst  = m_lost;
      r.hp   = 32'(m_hp);
      r.hp4  = 32'(m_hp4);
      exp_now = q1;
      q1 = q0;
      q0 = r;
    end
  end

  always @(negedge iclk) begin
    if (!reset) begin
      check("rise",   64'(rise_tick),    64'(exp_now.rise));
      check("fall",   64'(fall_tick),    64'(exp_now.fall));
      check("hp",     64'(half_period),  64'(exp_now.hp));
      check("locked", 64'(locked),       64'(exp_now.lck));
      check("lost",   64'(lost),         64'(exp_now.lst));
      check("rise4",  64'(rise_tick4),   64'(exp_now.rise));
      check("fall4",  64'(fall_tick4),   64'(exp_now.fall));
      check("hp4",    64'(half_period4), 64'(exp_now.hp4));
      check("locked4", 64'(locked4),     64'(exp_now.lck));
      check("lost4",  64'(lost4),        64'(exp_now.lst));
    end
  end

  task automatic hold(input logic lvl, input int n);
    for (int k = 0; k < n; k++) begin
      islow = lvl;
      @(negedge iclk);
    end
  endtask

  initial begin
    reset = 1'b1;
    islow = 1'b0;
    repeat (2) @(negedge iclk);
    for (int i = 0; i < 6; i++) begin
      islow = (i % 2 == 1);
      @(negedge iclk);
      check("rst_rise",   64'(rise_tick),   64'd0);
      check("rst_fall",   64'(fall_tick),   64'd0);
      check("rst_hp",     64'(half_period), 64'd0);
      check("rst_locked", 64'(locked),      64'd0);
      check("rst_lost",   64'(lost),        64'd0);
    end
    islow = 1'b0;
    reset = 1'b0;
    hold(1'b0, 5);
    check("t1_no_tick", 64'(rise_tick | fall_tick), 64'd0);

    // First rise: tick in the cycle after the second edge following capture.
    islow = 1'b1;
    @(negedge iclk); check("t2_tick_c1", 64'(rise_tick), 64'd0);
    @(negedge iclk); check("t2_tick_c2", 64'(rise_tick), 64'd0);
    @(negedge iclk); check("t2_tick_c3", 64'(rise_tick), 64'd1);
    @(negedge iclk); check("t2_tick_c4", 64'(rise_tick), 64'd0);
    hold(1'b1, 4);
    check("t2_hp_first", 64'(half_period), 64'd0);
    hold(1'b0, 8);
    check("t2_hp8",      64'(half_period), 64'd8);
    check("t2_unlocked", 64'(locked),      64'd0);
    hold(1'b1, 8);
    hold(1'b0, 8);
    check("t2_pre_lock", 64'(locked),      64'd0);
    hold(1'b1, 8);
    check("t2_locked",   64'(locked),      64'd1);
    check("t2_hp",       64'(half_period), 64'd8);

    hold(1'b0, 9);
    hold(1'b1, 10);
    check("t3_keep_lock", 64'(locked),      64'd1);
    check("t3_hp9",       64'(half_period), 64'd9);
    hold(1'b0, 8);
    check("t3_lost",      64'(lost),        64'd1);
    check("t3_unlocked",  64'(locked),      64'd0);
    check("t3_hp10",      64'(half_period), 64'd10);

    hold(1'b1, 8);
    check("t5_acq_lost",   64'(lost),   64'd0);
    check("t5_acq_locked", 64'(locked), 64'd0);
    hold(1'b0, 8);
    hold(1'b1, 8);
    hold(1'b0, 8);
    check("t5_not_yet",    64'(locked), 64'd0);
    hold(1'b1, 8);
    check("t5_relocked",   64'(locked), 64'd1);

    hold(1'b1, 32);
    check("t4_stall_lost", 64'(lost),         64'd1);
    check("t4_unlocked",   64'(locked),       64'd0);
    check("t4_hp_kept",    64'(half_period),  64'd8);
    check("t4_hp4_kept",   64'(half_period4), 64'd8);
    hold(1'b0, 8);
    check("t4_hp40",       64'(half_period),  64'd40);
    check("t4_hp4_sat",    64'(half_period4), 64'd15);
    check("t4_acq",        64'(lost),         64'd0);

    hold(1'b1, 8);
    hold(1'b0, 8);
    hold(1'b1, 40);
    hold(1'b0, 8);
    check("t6_hp4_sat",  64'(half_period4), 64'd15);
    check("t6_hp40",     64'(half_period),  64'd40);
    check("t6_no_lock4", 64'(locked4),      64'd0);
    check("t6_no_lock",  64'(locked),       64'd0);
    hold(1'b1, 8);
    hold(1'b0, 8);
    hold(1'b1, 8);
    check("t6_no_lock4b", 64'(locked4), 64'd0);
    hold(1'b0, 8);
    check("t6_lock4",     64'(locked4), 64'd1);
    check("t6_lock",      64'(locked),  64'd1);
    hold(1'b0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
